// File: rtl/spi_mem_if.sv
// Request/response handshake between the control unit and the SPI memory controller.
// The CU drives the request side (master); the controller answers with done/rdata (slave).
interface spi_mem_if;
    logic        req;
    logic        sel_ram;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        done;
    logic        busy;

    modport master (output req, sel_ram, we, addr, wdata, input rdata, done, busy);
    modport slave  (input req, sel_ram, we, addr, wdata, output rdata, done, busy);
endinterface

// File: rtl/spi_mem_ctrl.sv
// Single-byte SPI transaction engine: one flash read or one RAM read/write per CU request.
// Mode 0 (SCLK idle low). done pulses one clock after the transaction has fully wound down.
module spi_mem_ctrl #(
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned ADDR_BITS = 24,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic      clk,
    input  logic      rst,
    spi_mem_if.slave  bus,
    output logic      spi_sclk,
    output logic      spi_mosi,
    input  logic      spi_miso,
    output logic      spi_cs_rom_n,
    output logic      spi_cs_ram_n
);
    localparam int unsigned N     = 16 + ADDR_BITS;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(N);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FINISH, DONE, WAIT_REL} state_t;

    state_t           state, state_nxt;
    logic             sel_q, we_q;
    logic [N-1:0]     tx_q;
    logic [7:0]       rx_q;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       rdata_q;
    logic             done_q;

    logic accept, in_load, in_shift, in_finish, in_done;
    logic half_end, last_bit;

    assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit = half_end && spi_sclk && (bit_cnt == BIT_W'(N - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.req) state_nxt = (bus.we && !bus.sel_ram) ? DONE : LOAD;
            LOAD:     state_nxt = SHIFT;
            SHIFT:    if (last_bit) state_nxt = FINISH;
            FINISH:   state_nxt = DONE;
            DONE:     state_nxt = WAIT_REL;
            WAIT_REL: if (!bus.req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        accept    = 1'b0;
        in_load   = 1'b0;
        in_shift  = 1'b0;
        in_finish = 1'b0;
        in_done   = 1'b0;
        bus.busy  = (state != IDLE);
        case (state)
            IDLE:    accept    = bus.req;
            LOAD:    in_load   = 1'b1;
            SHIFT:   in_shift  = 1'b1;
            FINISH:  in_finish = 1'b1;
            DONE:    in_done   = 1'b1;
            default: ;
        endcase
    end

    // Pins are registered and reset asynchronously so an abort releases CS_n and SCLK at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            tx_q         <= '0;
            rx_q         <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_cs_rom_n <= 1'b1;
            spi_cs_ram_n <= 1'b1;
        end else begin
            done_q <= in_done;
            if (accept) begin
                sel_q <= bus.sel_ram;
                we_q  <= bus.we;
                tx_q  <= {bus.we ? CMD_WRITE : CMD_READ, ADDR_BITS'(bus.addr),
                          bus.we ? bus.wdata : 8'h00};
            end
            if (in_load) begin
                spi_cs_rom_n <= sel_q;
                spi_cs_ram_n <= !sel_q;
                spi_mosi     <= tx_q[N-1];
                spi_sclk     <= 1'b0;
                div_cnt      <= '0;
                bit_cnt      <= '0;
            end
            if (in_shift) begin
                if (!half_end) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (!spi_sclk) begin
                        spi_sclk <= 1'b1;
                        rx_q     <= {rx_q[6:0], spi_miso};
                    end else if (last_bit) begin
                        spi_sclk     <= 1'b0;
                        spi_mosi     <= 1'b0;
                        spi_cs_rom_n <= 1'b1;
                        spi_cs_ram_n <= 1'b1;
                    end else begin
                        // Falling SCLK: the next bit moves onto MOSI for the device to catch.
                        spi_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + 1'b1;
                        tx_q     <= {tx_q[N-2:0], 1'b0};
                        spi_mosi <= tx_q[N-2];
                    end
                end
            end
            if (in_finish && !we_q) rdata_q <= rx_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (CLK_DIV 1 and 3), each with a bit-level flash/RAM model.
// Expected values come from a transaction-level reference model, not from the DUT.
module tb_spi_mem_ctrl;
    localparam int N = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_mem_if bus0 ();
    spi_mem_if bus1 ();
    logic sclk0, mosi0, miso0, cs_rom_n0, cs_ram_n0;
    logic sclk1, mosi1, miso1, cs_rom_n1, cs_ram_n1;

    spi_mem_ctrl #(.CLK_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .spi_sclk(sclk0), .spi_mosi(mosi0),
        .spi_miso(miso0), .spi_cs_rom_n(cs_rom_n0), .spi_cs_ram_n(cs_ram_n0));
    spi_mem_ctrl #(.CLK_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .spi_sclk(sclk1), .spi_mosi(mosi1),
        .spi_miso(miso1), .spi_cs_rom_n(cs_rom_n1), .spi_cs_ram_n(cs_ram_n1));

    int n_checks = 0;
    int n_fail   = 0;
    int divs [2] = '{1, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SPI device models (flash + RAM) ----------------
    logic [39:0] dev_bits [2] = '{40'h0, 40'h0};
    int          dev_nb   [2] = '{0, 0};
    logic        dev_prev [2] = '{1'b0, 1'b0};
    logic        dev_act  [2] = '{1'b0, 1'b0};
    logic        dev_sram [2] = '{1'b0, 1'b0};
    logic        dev_miso [2] = '{1'b0, 1'b0};
    logic [7:0]  dev_byte [2] = '{8'h0, 8'h0};
    logic [39:0] log_bits [2] = '{40'h0, 40'h0};
    int          log_nb   [2] = '{0, 0};
    logic        log_ram  [2] = '{1'b0, 1'b0};
    int          cs_count [2] = '{0, 0};
    int          viol     [2] = '{0, 0};
    logic [7:0]  dev_ram [int];

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return (a == 24'h000123) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h3C);
    endfunction

    function automatic logic [7:0] dev_ram_rd(input int k, input logic [15:0] a);
        int key = k * 65536 + int'(a);
        return dev_ram.exists(key) ? dev_ram[key] : 8'h00;
    endfunction

    // Called #1 after each clk edge: mode-0 device, garbage on MISO while SCLK is high.
    task automatic dev_step(input int k, input logic sc, input logic mo, input logic crn,
                            input logic cmn, output logic mi);
        logic active;
        active = !crn || !cmn;
        mi = dev_miso[k];
        if (!crn && !cmn) viol[k]++;
        if (!active && sc) viol[k]++;
        if (active && !dev_act[k]) begin
            dev_nb[k] = 0;
            dev_bits[k] = '0;
            dev_sram[k] = !cmn;
            cs_count[k]++;
        end
        if (!active && dev_act[k]) begin
            log_bits[k] = dev_bits[k];
            log_nb[k] = dev_nb[k];
            log_ram[k] = dev_sram[k];
            if (dev_sram[k] && dev_nb[k] == 40 && dev_bits[k][39:32] == 8'h02)
                dev_ram[k * 65536 + int'(dev_bits[k][23:8])] = dev_bits[k][7:0];
        end
        if (active) begin
            if (sc && !dev_prev[k]) begin
                dev_bits[k] = {dev_bits[k][38:0], mo};
                dev_nb[k]++;
                if (dev_nb[k] == 32)
                    dev_byte[k] = dev_sram[k] ? dev_ram_rd(k, dev_bits[k][15:0])
                                              : rom_byte(dev_bits[k][23:0]);
            end
            if (sc) mi = 1'($urandom);
            else if (dev_prev[k] && dev_nb[k] >= 32 && dev_nb[k] < 40)
                mi = dev_byte[k][7 - (dev_nb[k] - 32)];
        end
        dev_prev[k] = sc;
        dev_act[k]  = active;
        dev_miso[k] = mi;
    endtask

    logic m0, m1;
    always @(posedge clk) begin
        #1;
        dev_step(0, sclk0, mosi0, cs_rom_n0, cs_ram_n0, m0);
        miso0 = m0;
    end
    always @(posedge clk) begin
        #1;
        dev_step(1, sclk1, mosi1, cs_rom_n1, cs_ram_n1, m1);
        miso1 = m1;
    end

    // ---------------- transaction-level reference model ----------------
    logic [7:0] ref_ram [int];
    logic [7:0] ref_rdata [2] = '{8'h00, 8'h00};

    task automatic model_apply(input int k, input bit sel, input bit we, input logic [15:0] a,
                               input logic [7:0] d, output int lat, output logic [7:0] rd);
        int key = k * 65536 + int'(a);
        if (we && !sel) begin
            lat = 1;
        end else begin
            lat = 2 * divs[k] * N + 3;
            if (we) ref_ram[key] = d;
            else ref_rdata[k] = sel ? (ref_ram.exists(key) ? ref_ram[key] : 8'h00)
                                    : rom_byte({8'h00, a});
        end
        rd = ref_rdata[k];
    endtask

    // ---------------- bus access helpers ----------------
    task automatic drive(input int k, input logic r, input logic s, input logic w,
                         input logic [15:0] a, input logic [7:0] d);
        if (k == 0) begin
            bus0.req = r; bus0.sel_ram = s; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus1.req = r; bus1.sel_ram = s; bus1.we = w; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    function automatic logic get_done(input int k);
        return (k == 0) ? bus0.done : bus1.done;
    endfunction
    function automatic logic get_busy(input int k);
        return (k == 0) ? bus0.busy : bus1.busy;
    endfunction
    function automatic logic [7:0] get_rdata(input int k);
        return (k == 0) ? bus0.rdata : bus1.rdata;
    endfunction
    function automatic logic get_cs_n(input int k, input bit ram);
        if (k == 0) return ram ? cs_ram_n0 : cs_rom_n0;
        return ram ? cs_ram_n1 : cs_rom_n1;
    endfunction

    task automatic run_txn(input int k, input bit sel, input bit we, input logic [15:0] a,
                           input logic [7:0] d, input int hold, input bit drop,
                           input int exp_lat, input logic [7:0] exp_rd, input string name);
        int lat = -1, cs_cyc = 0, other_cyc = 0, busy_low = 0, extra = 0, cs0;
        bit illegal = we && !sel;
        bit released = 0;
        logic [7:0]  rd = 8'hxx;
        logic [39:0] exp_stream = {we ? 8'h02 : 8'h03, 8'h00, a, we ? d : 8'h00};
        cs0 = cs_count[k];
        @(negedge clk);
        drive(k, 1'b1, sel, we, a, d);
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) drive(k, !drop, !sel, !we, ~a, ~d);
            if (!get_busy(k)) busy_low++;
            if (!get_cs_n(k, sel)) cs_cyc++;
            if (!get_cs_n(k, !sel)) other_cyc++;
            if (get_done(k)) begin
                lat = c - 1;
                rd = get_rdata(k);
                break;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            if (get_done(k)) extra++;
        end
        drive(k, 1'b0, sel, we, a, d);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (!get_busy(k)) begin
                released = 1;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_rdata"}, 64'(rd), 64'(exp_rd));
        check({name, "_extra_done"}, 64'(extra), 64'd0);
        check({name, "_busy_low"}, 64'(busy_low), 64'd0);
        check({name, "_cs_cycles"}, 64'(cs_cyc), illegal ? 64'd0 : 64'(2 * divs[k] * N));
        check({name, "_other_cs"}, 64'(other_cyc), 64'd0);
        check({name, "_cs_count"}, 64'(cs_count[k] - cs0), illegal ? 64'd0 : 64'd1);
        check({name, "_released"}, 64'(released), 64'd1);
        check({name, "_violations"}, 64'(viol[k]), 64'd0);
        if (!illegal) begin
            check({name, "_mosi_bits"}, 64'(log_nb[k]), 64'd40);
            check({name, "_mosi_stream"}, 64'(log_bits[k]), 64'(exp_stream));
            check({name, "_ram_sel"}, 64'(log_ram[k]), 64'(sel));
        end
    endtask

    typedef struct {
        int          k;
        bit          sel;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          hold;
        bit          drop;
        int          exp_lat;
        logic [7:0]  exp_rd;
        string       name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat;
        logic [7:0] rd;
        bit reached;
        int done_seen;

        vecs[0] = '{0, 1'b0, 1'b0, 16'h0123, 8'h00, 0,  1'b0, 83,  8'hA5, "rom_rd_0123"};
        vecs[1] = '{0, 1'b0, 1'b0, 16'h0123, 8'h00, 20, 1'b0, 83,  8'hA5, "held_req"};
        vecs[2] = '{0, 1'b1, 1'b1, 16'hBEEF, 8'h5C, 0,  1'b1, 83,  8'hA5, "ram_wr_beef"};
        vecs[3] = '{0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 0,  1'b0, 83,  8'h5C, "ram_rd_beef"};
        vecs[4] = '{0, 1'b0, 1'b1, 16'h4444, 8'h77, 0,  1'b0, 1,   8'h5C, "rom_wr_illegal"};
        vecs[5] = '{1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 0,  1'b0, 243, 8'h3C, "div3_rom_ffff"};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);
        check("rst_done0", 64'(bus0.done), 64'd0);
        check("rst_busy0", 64'(bus0.busy), 64'd0);
        check("rst_rdata0", 64'(bus0.rdata), 64'd0);
        check("rst_pins0", 64'({sclk0, mosi0, cs_rom_n0, cs_ram_n0}), 64'b0011);
        check("rst_done1", 64'(bus1.done), 64'd0);
        check("rst_busy1", 64'(bus1.busy), 64'd0);
        check("rst_rdata1", 64'(bus1.rdata), 64'd0);
        check("rst_pins1", 64'({sclk1, mosi1, cs_rom_n1, cs_ram_n1}), 64'b0011);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            model_apply(vecs[i].k, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
            run_txn(vecs[i].k, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].hold, vecs[i].drop, vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].name);
        end

        // Reset partway through the shift phase aborts without a done pulse.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0123, 8'h00);
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (dev_nb[0] >= 17) begin
                reached = 1;
                break;
            end
        end
        check("abort_reached_bit17", 64'(reached), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_cs_released", 64'({cs_rom_n0, cs_ram_n0}), 64'b11);
        check("abort_sclk_low", 64'(sclk0), 64'd0);
        check("abort_busy_low", 64'(bus0.busy), 64'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus0.done || bus1.done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        rst = 1'b0;
        ref_rdata[0] = 8'h00;
        ref_rdata[1] = 8'h00;
        check("abort_rdata_cleared", 64'(bus0.rdata), 64'd0);
        model_apply(0, 1'b0, 1'b0, 16'h0000, 8'h00, lat, rd);
        run_txn(0, 1'b0, 1'b0, 16'h0000, 8'h00, 0, 1'b0, lat, rd, "post_abort_rom_rd");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 24; i++) begin
            int k = ($urandom_range(0, 3) == 0) ? 1 : 0;
            bit sel = 1'($urandom);
            bit we = 1'($urandom);
            logic [15:0] a = sel ? (16'hBEE8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            logic [7:0] d = 8'($urandom);
            model_apply(k, sel, we, a, d, lat, rd);
            run_txn(k, sel, we, a, d, int'($urandom_range(0, 3)), 1'($urandom), lat, rd,
                    $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
